// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared types and sizing helpers for the sequential Booth multiplier.
//   state_t      - controller state encoding (IDLE, RUN, DONE)
//   booth_ext    - operand width after the 2-bit sign/zero extension
//   booth_cycles - RUN cycles needed for a given width and steps-per-cycle
package booth_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned booth_ext(input int unsigned width);
    return width + 2;
  endfunction

  function automatic int unsigned booth_cycles(input int unsigned width,
                                               input int unsigned steps);
    return (width + 2) / steps;
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// booth_step: one combinational radix-2 Booth step.
//   p      - partial state {A[EXT], Q[EXT], q_m1}
//   m      - extended multiplicand
//   p_next - state after the conditional add/sub and the arithmetic right shift
module booth_step #(
  parameter int unsigned EXT = 34
) (
  input  logic [2*EXT:0] p,
  input  logic [EXT-1:0] m,
  output logic [2*EXT:0] p_next
);

  logic [EXT-1:0] a;
  logic [EXT-1:0] a_sum;

  always_comb begin
    a = p[2*EXT:EXT+1];
    case (p[1:0])
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a - m;
      default: a_sum = a;
    endcase
    // Shift {A, Q, q_m1} right by one, replicating A's MSB; Q[0] becomes q_m1.
    p_next = {a_sum[EXT-1], a_sum, p[EXT:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-2 Booth multiplier, signed/unsigned per operation.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - operand handshake (in_ready high only in IDLE)
//   is_signed            - 1: two's-complement operands, 0: unsigned
//   in_a, in_b           - multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready  - result handshake; product held until taken
//   product              - 2*WIDTH-bit result
//   busy                 - high in RUN or DONE
module booth_mult_seq
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned EXT = booth_ext(WIDTH);
  localparam int unsigned N   = booth_cycles(WIDTH, STEPS_PER_CYCLE);
  localparam int unsigned CW  = $clog2(N + 1);

  generate
    if (STEPS_PER_CYCLE == 0 || (EXT % STEPS_PER_CYCLE) != 0) begin : g_bad_spc
      $error("booth_mult_seq: STEPS_PER_CYCLE must divide WIDTH+2");
    end
  endgenerate

  state_t          state;
  logic [EXT-1:0]  m_reg;
  logic [2*EXT:0]  p_reg;
  logic [CW-1:0]   cnt;
  logic [EXT-1:0]  ext_a;
  logic [EXT-1:0]  ext_b;

  logic [STEPS_PER_CYCLE:0][2*EXT:0] chain;

  // The 2-bit extension keeps the unsigned MSB out of the Booth sign position,
  // so the same signed datapath serves both modes.
  always_comb begin
    ext_a = is_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
    ext_b = is_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
  end

  assign chain[0] = p_reg;

  generate
    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
      booth_step #(.EXT(EXT)) u_step (
        .p      (chain[g]),
        .m      (m_reg),
        .p_next (chain[g+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      p_reg     <= '0;
      m_reg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= ext_a;
            p_reg    <= {{EXT{1'b0}}, ext_b, 1'b0};
            cnt      <= CW'(N);
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          p_reg <= chain[STEPS_PER_CYCLE];
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            product   <= chain[STEPS_PER_CYCLE][2*WIDTH:1];
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and reference-model checks for booth_mult_seq,
// with one instance at one step per cycle and one at two steps per cycle
// sharing the same input stimulus.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        is_signed;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_ready;

  logic        in_ready1, out_valid1, busy1;
  logic [63:0] product1;
  logic        in_ready2, out_valid2, busy2;
  logic [63:0] product2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .is_signed (is_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .product   (product1),
    .busy      (busy1)
  );

  booth_mult_seq #(.WIDTH(32), .STEPS_PER_CYCLE(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .is_signed (is_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .product   (product2),
    .busy      (busy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid  = 1'b1;
    is_signed = s;
    in_a      = a;
    in_b      = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    // Operands may change freely once accepted.
    in_a      = ~a;
    in_b      = ~b;
    is_signed = ~s;
  endtask

  // Cycles after the accept edge at which each out_valid is first seen; 0 = timed out.
  task automatic wait_done(output int l1, output int l2);
    l1 = 0;
    l2 = 0;
    for (int c = 1; c <= 60 && (l1 == 0 || l2 == 0); c++) begin
      @(posedge clk);
      #1;
      if (out_valid1 && l1 == 0) l1 = c;
      if (out_valid2 && l2 == 0) l2 = c;
    end
  endtask

  task automatic handoff(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " in_ready1 after handoff"}, 64'(in_ready1), 64'd1);
    check({tag, " in_ready2 after handoff"}, 64'(in_ready2), 64'd1);
    check({tag, " out_valid1 after handoff"}, 64'(out_valid1), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int l1, l2;
    start_op(s, a, b);
    check({tag, " busy1 in run"}, 64'(busy1), 64'd1);
    check({tag, " in_ready1 in run"}, 64'(in_ready1), 64'd0);
    wait_done(l1, l2);
    check({tag, " latency spc1"}, 64'(l1), 64'd34);
    check({tag, " latency spc2"}, 64'(l2), 64'd17);
    check({tag, " product spc1"}, product1, exp);
    check({tag, " product spc2"}, product2, exp);
    handoff(tag);
  endtask

  initial begin
    int          l1, l2;
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rs;

    rst       = 1'b1;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset in_ready", 64'(in_ready1), 64'd1);
    check("reset out_valid", 64'(out_valid1), 64'd0);
    check("reset busy", 64'(busy1), 64'd0);
    check("reset product", product1, 64'd0);

    run_op("umax",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    run_op("s_m3x5",    1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1);
    run_op("s_minsq",   1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    run_op("s_m1m1",    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
    run_op("u_ffx2",    1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE);
    run_op("s_ffx2",    1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE);
    run_op("u_1234",    1'b0, 32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080);
    run_op("s_minmax",  1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000);
    run_op("zero",      1'b1, 32'h00000000, 32'hDEADBEEF, 64'h0000000000000000);

    // Back-pressure: result must hold while in_valid pulses are ignored.
    start_op(1'b0, 32'd1000, 32'd1000);
    wait_done(l1, l2);
    check("bp latency", 64'(l1), 64'd34);
    held = product1;
    check("bp product", held, 64'd1000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp product stable", product1, 64'd1000000);
      check("bp in_ready low", 64'(in_ready1), 64'd0);
      check("bp out_valid held", 64'(out_valid1), 64'd1);
    end
    handoff("bp");

    // Reset dominates an offered operation.
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst+valid busy", 64'(busy1), 64'd0);
    check("rst+valid in_ready", 64'(in_ready1), 64'd1);

    // Reset in the middle of RUN discards the operation.
    start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrun out_valid", 64'(out_valid1), 64'd0);
    check("midrun product", product1, 64'd0);
    check("midrun in_ready", 64'(in_ready1), 64'd1);
    check("midrun busy", 64'(busy1), 64'd0);
    check("midrun product spc2", product2, 64'd0);
    run_op("after_rst", 1'b0, 32'd7, 32'd6, 64'd42);

    // Random pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      start_op(rs, ra, rb);
      wait_done(l1, l2);
      check("rand product spc1", product1, ref_mul(rs, ra, rb));
      check("rand product spc2", product2, ref_mul(rs, ra, rb));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
